// File: rtl/mac_psum_drain.sv
// mac_psum_drain: consumer end of the MAC bank result interface.
// Accumulates NUM_MAC x 4 partial sums over input-channel passes, then drains
// one quantized word per MAC ({q3,q2,q1,q0}) through a valid/ready port.
// Build option: define MAC_PSUM_DRAIN_ROUND_EN to round half-up before the shift
// (default build truncates).

// One MAC group: four saturating accumulators.
module mac_psum_lane #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 24
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    load,
    input  logic                    add,
    input  logic [4*PSUM_W-1:0]     iPsum,
    output logic [3:0][ACC_W-1:0]   oAcc
);
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    for (genvar k = 0; k < 4; k++) begin : gAcc
        logic [PSUM_W-1:0] p;
        logic [ACC_W-1:0]  ext;
        logic [ACC_W:0]    sum;
        logic [ACC_W-1:0]  satSum;
        logic [ACC_W-1:0]  acc;

        assign p       = iPsum[k*PSUM_W +: PSUM_W];
        assign ext     = {{(ACC_W-PSUM_W){p[PSUM_W-1]}}, p};
        assign sum     = {acc[ACC_W-1], acc} + {ext[ACC_W-1], ext};
        assign oAcc[k] = acc;

        // Overflow shows as disagreement of the two top sum bits; clamp to the true sign.
        always_comb begin
            satSum = sum[ACC_W-1:0];
            if (sum[ACC_W] != sum[ACC_W-1])
                satSum = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end

        // Load on the first pass, saturating add on later passes.
        always_ff @(posedge clk) begin
            if (!rstn)     acc <= '0;
            else if (load) acc <= ext;
            else if (add)  acc <= satSum;
        end
    end
endmodule

module mac_psum_drain #(
    parameter int NUM_MAC = 12,
    parameter int PSUM_W  = 20,
    parameter int ACC_W   = 24
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        vld_i,
    input  logic                        iFirst,
    input  logic                        iLast,
    input  logic [4:0]                  iShift,
    input  logic [NUM_MAC*4*PSUM_W-1:0] iPsum,
    output logic                        oVld,
    input  logic                        iRdy,
    output logic [31:0]                 oData,
    output logic [3:0]                  oAddr,
    output logic                        oBusy,
    output logic                        oDone,
    output logic                        oErr
);
    typedef enum logic {IDLE, DRAIN} state_t;

    localparam logic [ACC_W:0] ONE = {{ACC_W{1'b0}}, 1'b1};

    state_t                         state, nextState;
    logic [3:0]                     idx;
    logic [4:0]                     shiftReg;
    logic                           errReg;
    logic [NUM_MAC-1:0][3:0][ACC_W-1:0] acc;
    logic [3:0][7:0]                qWord;
    logic                           accept, lastIdx, hsk;

    assign accept  = (state == IDLE) && vld_i;
    assign lastIdx = (idx == 4'(NUM_MAC-1));
    assign hsk     = (state == DRAIN) && iRdy;

    // ReLU, optional round, shift, then clamp to an unsigned byte.
    function automatic logic [7:0] quant(input logic [ACC_W-1:0] a, input logic [4:0] sh);
        logic [ACC_W:0] v;
        logic [7:0]     q;
        v = {1'b0, a};
`ifdef MAC_PSUM_DRAIN_ROUND_EN
        if (sh != 5'd0) v = v + (ONE << (sh - 5'd1));
`endif
        v = v >> sh;
        if (a[ACC_W-1])      q = 8'd0;
        else if (|v[ACC_W:8]) q = 8'hFF;
        else                 q = v[7:0];
        return q;
    endfunction

    for (genvar m = 0; m < NUM_MAC; m++) begin : gLane
        mac_psum_lane #(.PSUM_W(PSUM_W), .ACC_W(ACC_W)) uLane (
            .clk   (clk),
            .rstn  (rstn),
            .load  (accept && iFirst),
            .add   (accept && !iFirst),
            .iPsum (iPsum[m*4*PSUM_W +: 4*PSUM_W]),
            .oAcc  (acc[m])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= nextState;
    end

    // Next state: last pass starts the drain, final handshake ends it.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (vld_i && iLast) nextState = DRAIN;
            DRAIN:   if (iRdy && lastIdx) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Drain index, latched shift and sticky error for input arriving mid-drain.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idx      <= '0;
            shiftReg <= '0;
            errReg   <= 1'b0;
        end else begin
            if (accept && iLast) begin
                idx      <= '0;
                shiftReg <= iShift;
            end else if (hsk) begin
                idx <= lastIdx ? 4'd0 : idx + 4'd1;
            end
            if (state == DRAIN && vld_i) errReg <= 1'b1;
        end
    end

    // Quantized word for the MAC currently addressed.
    always_comb begin
        qWord = '0;
        for (int k = 0; k < 4; k++) qWord[k] = quant(acc[idx][k], shiftReg);
    end

    // Port outputs; oVld depends only on registered state.
    always_comb begin
        oVld  = (state == DRAIN);
        oBusy = (state == DRAIN);
        oAddr = (state == DRAIN) ? idx : 4'd0;
        oData = (state == DRAIN) ? qWord : 32'd0;
        oDone = hsk && lastIdx;
        oErr  = errReg;
    end
endmodule

// File: tb/tb_mac_psum_drain.sv
// Randomized bench for mac_psum_drain against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mac_psum_drain;
    localparam int NUM_MAC = 12;
    localparam int PSUM_W  = 20;
    localparam int ACC_W   = 24;
    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    logic clk, rstn, vld_i, iFirst, iLast, iRdy;
    logic [4:0] iShift;
    logic [NUM_MAC*4*PSUM_W-1:0] iPsum;
    logic oVld, oBusy, oDone, oErr;
    logic [31:0] oData;
    logic [3:0] oAddr;

    mac_psum_drain #(.NUM_MAC(NUM_MAC), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rstn(rstn), .vld_i(vld_i), .iFirst(iFirst), .iLast(iLast),
        .iShift(iShift), .iPsum(iPsum), .oVld(oVld), .iRdy(iRdy), .oData(oData),
        .oAddr(oAddr), .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int nChk = 0, nFail = 0;
    longint macc[NUM_MAC][4];
    int ps[NUM_MAC][4];
    int mShift;
    bit mErr;
    logic [31:0] seen[NUM_MAC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChk++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qModel(longint a, int sh);
        longint v;
        if (a < 0) return 0;
        v = a;
`ifdef MAC_PSUM_DRAIN_ROUND_EN
        if (sh > 0) v = v + (64'sd1 << (sh - 1));
`endif
        v = v / (64'sd1 << sh);
        return (v > 255) ? 255 : int'(v);
    endfunction

    function automatic logic [31:0] mWord(int m);
        logic [31:0] w;
        w = '0;
        for (int k = 0; k < 4; k++) w[k*8 +: 8] = 8'(qModel(macc[m][k], mShift));
        return w;
    endfunction

    task automatic clearPs();
        for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++) ps[m][k] = 0;
    endtask

    task automatic randPs();
        int mode;
        mode = int'($urandom_range(0, 2));
        for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++)
            case (mode)
                0: ps[m][k] = int'($urandom_range(0, 1048575)) - 524288;
                1: ps[m][k] = int'($urandom_range(0, 600)) - 300;
                default: ps[m][k] = int'($urandom_range(0, 10000)) - 4000;
            endcase
    endtask

    task automatic drivePs();
        for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++)
            iPsum[(m*4+k)*PSUM_W +: PSUM_W] = PSUM_W'(ps[m][k]);
    endtask

    task automatic doReset();
        rstn = 0; vld_i = 0; iFirst = 0; iLast = 0; iRdy = 0; iShift = 0; iPsum = '0;
        repeat (2) @(negedge clk);
        chk("rst oVld", oVld, 0);  chk("rst oData", oData, 0); chk("rst oAddr", oAddr, 0);
        chk("rst oBusy", oBusy, 0); chk("rst oDone", oDone, 0); chk("rst oErr", oErr, 0);
        rstn = 1;
        for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++) macc[m][k] = 0;
        mErr = 0; mShift = 0;
    endtask

    // Called at a negedge while idle; returns at the following negedge.
    task automatic sendPass(input bit first, input bit last, input int sh);
        longint s;
        drivePs();
        vld_i = 1; iFirst = first; iLast = last; iShift = 5'(sh);
        for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++) begin
            s = first ? longint'(ps[m][k]) : macc[m][k] + longint'(ps[m][k]);
            if (s > ACC_MAX) s = ACC_MAX;
            if (s < ACC_MIN) s = ACC_MIN;
            macc[m][k] = s;
        end
        if (last) mShift = sh;
        @(negedge clk);
        vld_i = 0; iFirst = 1'($urandom); iLast = 1'($urandom); iShift = 5'($urandom);
        if (last) chk("latency oVld", oVld, 1);
    endtask

    // rdyMode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
    task automatic drainTile(input int rdyMode, input int injIdx, input int rstIdx);
        int e, cyc;
        bit inj;
        e = 0; cyc = 0; inj = 0;
        while (e < NUM_MAC && cyc < 200) begin
            case (rdyMode)
                0: iRdy = 1;
                1: iRdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: iRdy = 1'($urandom_range(0, 1));
            endcase
            if (e == rstIdx) begin
                rstn = 0;
                @(negedge clk);
                chk("midrst oVld", oVld, 0);  chk("midrst oData", oData, 0);
                chk("midrst oAddr", oAddr, 0); chk("midrst oBusy", oBusy, 0);
                chk("midrst oDone", oDone, 0); chk("midrst oErr", oErr, 0);
                rstn = 1;
                for (int m = 0; m < NUM_MAC; m++) for (int k = 0; k < 4; k++) macc[m][k] = 0;
                mErr = 0;
                @(negedge clk);
                chk("postrst oVld", oVld, 0);
                return;
            end
            if (e == injIdx && !inj) begin
                randPs(); drivePs();
                vld_i = 1; iFirst = 1; iLast = 1; iShift = 5'($urandom);
                inj = 1;
            end
            #1;
            chk("drain oVld", oVld, 1);
            chk("drain oBusy", oBusy, 1);
            chk("drain oAddr", oAddr, e);
            chk("drain oData", oData, mWord(e));
            chk("drain oDone", oDone, (iRdy && e == NUM_MAC-1));
            chk("drain oErr", oErr, mErr);
            if (iRdy) seen[e] = oData;
            @(negedge clk);
            if (vld_i) begin mErr = 1; vld_i = 0; end
            if (iRdy) e++;
            cyc++;
        end
        if (e < NUM_MAC) chk("drain timeout", e, NUM_MAC);
        else begin
            chk("idle oVld", oVld, 0);
            chk("idle oBusy", oBusy, 0);
            chk("idle oErr", oErr, mErr);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int np;
        doReset();

        // Single pass, shift 2, mixed signs and an oversize value.
        clearPs();
        ps[0][0] = 102; ps[0][1] = 200; ps[0][2] = -5; ps[0][3] = 20000;
        sendPass(1, 1, 2);
        drainTile(0, -1, -1);
`ifdef MAC_PSUM_DRAIN_ROUND_EN
        chk("tp1 word0", seen[0], 32'hFF00321A);
`else
        chk("tp1 word0", seen[0], 32'hFF003219);
`endif

        // Two passes: positive total and a negative total.
        clearPs(); ps[3][1] = 60;  ps[3][2] = 10;  sendPass(1, 0, 0);
        clearPs(); ps[3][1] = -20; ps[3][2] = -30; sendPass(0, 1, 0);
        drainTile(0, -1, -1);
        chk("tp2 mac3", seen[3], 32'h0000_2800);

        // Saturation both ways: k0 rides up then down, k1 the mirror image.
        for (int p = 0; p < 34; p++) begin
            clearPs();
            ps[0][0] = (p < 17) ? 524287 : (p < 33 ? -524288 : 0);
            ps[0][1] = (p < 17) ? -524288 : 524287;
            sendPass(p == 0, p == 33, 12);
        end
        drainTile(2, -1, -1);
`ifdef MAC_PSUM_DRAIN_ROUND_EN
        chk("sat mac0", seen[0], 32'h0000_8000);
`else
        chk("sat mac0", seen[0], 32'h0000_7F00);
`endif

        // Backpressure pattern.
        randPs(); sendPass(1, 1, int'($urandom_range(0, 15)));
        drainTile(1, -1, -1);

        // Input arriving mid-drain, then error persists over the next tile.
        randPs(); sendPass(1, 1, 4);
        drainTile(2, 5, -1);
        chk("err sticky", oErr, 1);
        randPs(); sendPass(1, 1, 3);
        drainTile(2, -1, -1);

        // Input in the same cycle as the final handshake.
        randPs(); sendPass(1, 1, 5);
        drainTile(0, 11, -1);

        // Reset mid-drain, then a fresh tile drains from address 0.
        randPs(); sendPass(1, 1, 6);
        drainTile(2, -1, 7);
        randPs(); sendPass(1, 1, 3);
        drainTile(0, -1, -1);

        // Random multi-pass tiles.
        for (int t = 0; t < 8; t++) begin
            np = int'($urandom_range(1, 4));
            for (int p = 0; p < np; p++) begin
                randPs();
                sendPass(p == 0, p == np-1, int'($urandom_range(0, 15)));
                if (p != np-1) repeat (int'($urandom_range(0, 2))) @(negedge clk);
            end
            drainTile(2, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end
endmodule
